// File: rtl/conv_window_3x3.sv
// conv_window_3x3: 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers feed a shifting 3x3 register window; only valid-padding windows are emitted.
module conv_window_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [8:0][DATA_W-1:0] win_data,
  output logic                   frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      win_valid_q, win_valid_d;
  logic                      frame_done_q, frame_done_d;
  logic [8:0][DATA_W-1:0]    win_data_q, win_data_d;
  logic [8:0][DATA_W-1:0]    win_reg_q, win_reg_d;
  logic [8:0][DATA_W-1:0]    win_shift;
  logic [2:0][DATA_W-1:0]    new_col;
  logic [DATA_W-1:0]         lb0_mem [IMG_W];
  logic [DATA_W-1:0]         lb1_mem [IMG_W];
  logic                      accept;
  logic                      at_col_end;
  logic                      at_row_end;
  logic                      win_pos;
  logic                      win_taken;

  // Single output stage: a new pixel may enter whenever the held window leaves this cycle.
  assign in_ready   = !win_valid_q || win_ready;
  assign accept     = in_valid && in_ready && !clear;
  assign win_taken  = win_valid_q && win_ready;
  assign at_col_end = (col_q == COL_LAST);
  assign at_row_end = (row_q == ROW_LAST);
  assign win_pos    = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

  // Column entering the window: two rows up, one row up, current pixel.
  assign new_col[0] = lb1_mem[col_q];
  assign new_col[1] = lb0_mem[col_q];
  assign new_col[2] = in_data;

  always_comb begin
    win_shift = '0;
    for (int ky = 0; ky < 3; ky++) begin
      win_shift[3*ky]     = win_reg_q[3*ky+1];
      win_shift[3*ky + 1] = win_reg_q[3*ky+2];
      win_shift[3*ky + 2] = new_col[ky];
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    win_data_d   = win_data_q;
    win_reg_d    = win_reg_q;
    frame_done_d = 1'b0;
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      win_valid_d = 1'b0;
    end else if (accept) begin
      win_reg_d = win_shift;
      if (win_pos) begin
        win_data_d  = win_shift;
        win_valid_d = 1'b1;
      end else if (win_taken) begin
        win_valid_d = 1'b0;
      end
      if (at_col_end) begin
        col_d = '0;
        if (at_row_end) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (win_taken) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_reg_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      win_reg_q    <= win_reg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are always written before being read in a frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_q] <= lb0_mem[col_q];
      lb0_mem[col_q] <= in_data;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3: a 4x4 instance for the directed/random scenarios
// and a 28x28 instance for a full random frame, both compared against a frame-array model.
module tb_conv_window_3x3;

  localparam int DW = 16;
  typedef logic [8:0][DW-1:0] win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clear = 1'b0;

  logic          s_in_valid = 1'b0, s_in_ready, s_win_valid, s_win_ready = 1'b1, s_frame_done;
  logic [DW-1:0] s_in_data = '0;
  win_t          s_win_data;
  logic          l_in_valid = 1'b0, l_in_ready, l_win_valid, l_win_ready = 1'b1, l_frame_done;
  logic [DW-1:0] l_in_data = '0;
  win_t          l_win_data;

  conv_window_3x3 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .win_data(s_win_data),
    .frame_done(s_frame_done)
  );

  conv_window_3x3 #(.DATA_W(DW), .IMG_W(28), .IMG_H(28)) u_large (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .win_valid(l_win_valid), .win_ready(l_win_ready), .win_data(l_win_data),
    .frame_done(l_frame_done)
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int cyc = 0;

  logic [DW-1:0] pix_q[$];
  win_t          exp_q[$];
  int            exp_last[$];
  logic [DW-1:0] acc_q[$];
  int            acc_cyc[$];
  win_t          got_q[$];
  int            got_cyc[$];
  int            fd_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepted pixels, taken windows and frame_done pulses of the selected DUT.
  always @(negedge clk) begin
    if (sel == 0) begin
      if (!rst && !clear && s_in_valid && s_in_ready) begin acc_q.push_back(s_in_data); acc_cyc.push_back(cyc); end
      if (s_win_valid && s_win_ready) begin got_q.push_back(s_win_data); got_cyc.push_back(cyc); end
      if (s_frame_done) fd_cyc.push_back(cyc);
    end else begin
      if (!rst && !clear && l_in_valid && l_in_ready) begin acc_q.push_back(l_in_data); acc_cyc.push_back(cyc); end
      if (l_win_valid && l_win_ready) begin got_q.push_back(l_win_data); got_cyc.push_back(cyc); end
      if (l_frame_done) fd_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    acc_q.delete(); acc_cyc.delete(); got_q.delete(); got_cyc.delete(); fd_cyc.delete();
  endtask

  task automatic fill_seq(input int first, input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(DW'(first + i));
  endtask

  // Reference: each accepted pixel at (r,c) with r,c >= 2 closes the window of rows r-2..r, cols c-2..c.
  task automatic build_model(input int w, input int h);
    exp_q.delete(); exp_last.delete();
    for (int i = 0; i < pix_q.size(); i++) begin
      int fsz, base, k, r, c;
      win_t wv;
      fsz = w * h; base = (i / fsz) * fsz; k = i - base; r = k / w; c = k % w;
      if (r >= 2 && c >= 2) begin
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            wv[3*ky + kx] = pix_q[base + (r - 2 + ky) * w + (c - 2 + kx)];
        exp_q.push_back(wv);
        exp_last.push_back(i);
      end
    end
  endtask

  task automatic drive_in(input logic v, input logic [DW-1:0] d);
    if (sel == 0) begin s_in_valid = v; s_in_data = d; end
    else begin l_in_valid = v; l_in_data = d; end
  endtask

  task automatic drive_rdy(input logic b);
    if (sel == 0) s_win_ready = b; else l_win_ready = b;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_pct, input int rdy_pct);
    for (int i = lo; i <= hi; i++) begin
      bit done;
      int budget;
      logic v, rd;
      done = 0; budget = 0;
      while (!done) begin
        v = !(gap_pct > 0 && $urandom_range(99) < gap_pct);
        drive_in(v, v ? pix_q[i] : '0);
        drive_rdy(rdy_pct >= 100 ? 1'b1 : ($urandom_range(99) < rdy_pct));
        @(negedge clk);
        rd = (sel == 0) ? s_in_ready : l_in_ready;
        done = v && rd;
        @(posedge clk); #1;
        budget++;
        if (!done && budget > 1000) begin
          checks++; errors++;
          $display("FAIL send_timeout pixel %0d not accepted within %0d cycles", i, budget);
          done = 1;
        end
      end
    end
    drive_in(1'b0, '0);
  endtask

  task automatic drain(input int rdy_pct);
    for (int i = 0; i < 20; i++) begin
      drive_rdy(rdy_pct >= 100 ? 1'b1 : ($urandom_range(99) < rdy_pct));
      @(posedge clk); #1;
    end
    drive_rdy(1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (s_win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b exp 0", s_win_valid); end
    checks++; if (s_win_data !== '0) begin errors++; $display("FAIL reset_win_data got %h exp 0", s_win_data); end
    checks++; if (s_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", s_frame_done); end
    checks++; if (l_win_valid !== 1'b0) begin errors++; $display("FAIL reset_large_valid got %b exp 0", l_win_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", s_in_ready); end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    sel = 0; clear_logs(); fill_seq(1, 16); build_model(4, 4);
    send_range(0, 15, 0, 100); drain(100);
    checks++; if (got_q.size() !== 4 || exp_q.size() !== 4) begin errors++; $display("FAIL t1_count got %0d exp 4 (model %0d)", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() > 0 && (got_q[0][8] !== 16'd11 || got_q[0][0] !== 16'd1 || got_q[0][4] !== 16'd6)) begin
      errors++; $display("FAIL t1_first_window got %h exp corners 1/6/11", got_q[0]); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++; if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL t1_window%0d got %h exp %h", j, got_q[j], exp_q[j]); end
      checks++; if (acc_cyc.size() != 16 || got_cyc[j] !== acc_cyc[exp_last[j]] + 1) begin
        errors++; $display("FAIL t1_latency%0d got cycle %0d exp %0d", j, got_cyc[j], acc_cyc[exp_last[j]] + 1); end
    end
    checks++; if (fd_cyc.size() !== 1 || acc_cyc.size() != 16 || fd_cyc[0] !== acc_cyc[15] + 1) begin
      errors++; $display("FAIL t1_frame_done got %0d pulses exp 1 at cycle after pixel 16", fd_cyc.size()); end
    $display("test_stream windows %0d frame_done %0d", got_q.size(), fd_cyc.size());
  endtask

  task automatic test_back_to_back();
    sel = 0; clear_logs(); fill_seq(1, 32); build_model(4, 4);
    send_range(0, 31, 0, 100); drain(100);
    checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL t2_count got %0d exp 8", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++; if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL t2_window%0d got %h exp %h", j, got_q[j], exp_q[j]); end
    end
    checks++; if (got_q.size() > 4 && got_q[4][0] !== 16'd17) begin errors++; $display("FAIL t2_frame2_first got %0d exp 17", got_q[4][0]); end
    checks++; if (fd_cyc.size() !== 2) begin errors++; $display("FAIL t2_frame_done got %0d exp 2", fd_cyc.size()); end
    $display("test_back_to_back windows %0d frame_done %0d", got_q.size(), fd_cyc.size());
  endtask

  task automatic test_stall();
    win_t held;
    sel = 0; clear_logs(); fill_seq(1, 16); build_model(4, 4);
    send_range(0, 10, 0, 100);
    drive_rdy(1'b0);
    drive_in(1'b1, pix_q[11]);
    held = s_win_data;
    checks++; if (held !== exp_q[0]) begin errors++; $display("FAIL t3_held_window got %h exp %h", held, exp_q[0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (s_win_valid !== 1'b1 || s_win_data !== held || s_in_ready !== 1'b0) begin
        errors++; $display("FAIL t3_stall%0d valid %b ready %b data %h exp valid 1 ready 0 data %h", i, s_win_valid, s_in_ready, s_win_data, held); end
      @(posedge clk); #1;
    end
    send_range(11, 15, 0, 100); drain(100);
    checks++; if (acc_q.size() !== 16) begin errors++; $display("FAIL t3_accepts got %0d exp 16", acc_q.size()); end
    for (int i = 0; i < acc_q.size() && i < 16; i++) begin
      checks++; if (acc_q[i] !== pix_q[i]) begin errors++; $display("FAIL t3_pixel%0d got %0d exp %0d", i, acc_q[i], pix_q[i]); end
    end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL t3_count got %0d exp 4", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++; if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL t3_window%0d got %h exp %h", j, got_q[j], exp_q[j]); end
    end
    $display("test_stall windows %0d accepts %0d", got_q.size(), acc_q.size());
  endtask

  task automatic test_random_flow();
    sel = 0; clear_logs(); fill_seq(1, 16); build_model(4, 4);
    send_range(0, 15, 30, 50); drain(50);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL t4_count got %0d exp 4", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++; if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL t4_window%0d got %h exp %h", j, got_q[j], exp_q[j]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL t4_frame_done got %0d exp 1", fd_cyc.size()); end
    $display("test_random_flow windows %0d frame_done %0d", got_q.size(), fd_cyc.size());
  endtask

  task automatic test_clear();
    sel = 0; clear_logs(); fill_seq(1, 16);
    send_range(0, 6, 0, 100);
    clear = 1'b1;
    drive_in(1'b1, 16'hDEAD);
    @(posedge clk); #1;
    clear = 1'b0;
    drive_in(1'b0, '0);
    checks++; if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0) begin
      errors++; $display("FAIL t5_clear_state valid %b frame_done %b exp 0 0", s_win_valid, s_frame_done); end
    clear_logs(); build_model(4, 4);
    send_range(0, 15, 0, 100); drain(100);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL t5_clear_count got %0d exp 4", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++; if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL t5_clear_window%0d got %h exp %h", j, got_q[j], exp_q[j]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL t5_clear_frame_done got %0d exp 1", fd_cyc.size()); end
    $display("test_clear windows %0d frame_done %0d", got_q.size(), fd_cyc.size());
  endtask

  task automatic test_rst_mid();
    sel = 0; clear_logs(); fill_seq(1, 16);
    send_range(0, 11, 0, 100);
    rst = 1'b1;
    #1;
    checks++; if (s_win_valid !== 1'b0 || s_win_data !== '0) begin
      errors++; $display("FAIL t5_rst_async valid %b data %h exp 0 0", s_win_valid, s_win_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs(); build_model(4, 4);
    send_range(0, 15, 0, 100); drain(100);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL t5_rst_count got %0d exp 4", got_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++; if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL t5_rst_window%0d got %h exp %h", j, got_q[j], exp_q[j]); end
    end
    $display("test_rst_mid windows %0d", got_q.size());
  endtask

  task automatic test_full_frame();
    int bad;
    sel = 1; clear_logs();
    pix_q.delete();
    for (int i = 0; i < 28 * 28; i++) pix_q.push_back(DW'($urandom));
    build_model(28, 28);
    send_range(0, 28 * 28 - 1, 0, 100); drain(100);
    checks++; if (got_q.size() !== 676 || exp_q.size() !== 676) begin
      errors++; $display("FAIL t6_count got %0d exp 676 (model %0d)", got_q.size(), exp_q.size()); end
    bad = 0;
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_q[j]) begin
        errors++;
        if (bad < 5) $display("FAIL t6_window%0d got %h exp %h", j, got_q[j], exp_q[j]);
        bad++;
      end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL t6_frame_done got %0d exp 1", fd_cyc.size()); end
    $display("test_full_frame windows %0d frame_done %0d", got_q.size(), fd_cyc.size());
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_stall();
    test_random_flow();
    test_clear();
    test_rst_mid();
    test_full_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
